// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter: FSM encoding,
// port ids, request bundle and the word-range check.
package dmem_arb_pkg;

   typedef enum logic {
      ST_NORMAL    = 1'b0,
      ST_FORCE_DMA = 1'b1
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam int unsigned CNT_W = 8;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   // True when the word index addr[31:2] lies inside a memory of 'depth' words.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
      return 32'(addr[31:2]) < depth;
   endfunction

endpackage

// File: rtl/dmem_rsp_reg.sv
// Per-port response register: one-cycle valid pulse, load data hold and
// out-of-range flag, all updated from the cycle of the accept.
module dmem_rsp_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        accept,
   input  logic        is_load,
   input  logic        err,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= accept;
         if (accept) begin
            rsp_err <= err;
            // Out-of-range returns zero data; in-range stores keep the last load data.
            if (err) begin
               rsp_rdata <= '0;
            end else if (is_load) begin
               rsp_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU and a DMA requester,
// with a saturating wait counter that forces a DMA grant to bound starvation.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MEM_DEPTH    = 256,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req_valid,
   output logic             cpu_req_ready,
   input  logic             cpu_req_we,
   input  logic [31:0]      cpu_req_addr,
   input  logic [31:0]      cpu_req_wdata,
   output logic             cpu_rsp_valid,
   output logic [31:0]      cpu_rsp_rdata,
   output logic             cpu_rsp_err,
   input  logic             dma_req_valid,
   output logic             dma_req_ready,
   input  logic             dma_req_we,
   input  logic [31:0]      dma_req_addr,
   input  logic [31:0]      dma_req_wdata,
   output logic             dma_rsp_valid,
   output logic [31:0]      dma_rsp_rdata,
   output logic             dma_rsp_err,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             mem_we,
   output logic             mem_re,
   input  logic [31:0]      mem_rdata,
   output logic             dma_starved,
   output arb_state_e       dbg_state,
   output logic [CNT_W-1:0] dbg_starve_cnt
);

   // Handshake: a request transfers in any cycle where *_req_valid and
   // *_req_ready are both high; ready is the combinational grant and never
   // depends on ready of the other side. Requesters hold payload until accepted.

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_e       state, state_next;
   logic [CNT_W-1:0] starve_cnt, starve_cnt_next;
   logic             grant_any;
   logic             grant_port;
   mem_req_t         cpu_req, dma_req, sel_req;
   logic             sel_in_range;

   assign cpu_req = '{we: cpu_req_we, addr: cpu_req_addr, wdata: cpu_req_wdata};
   assign dma_req = '{we: dma_req_we, addr: dma_req_addr, wdata: dma_req_wdata};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_NORMAL;
         starve_cnt <= '0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_cnt_next;
      end
   end

   always_comb begin
      grant_any       = 1'b0;
      grant_port      = PORT_CPU;
      state_next      = state;
      starve_cnt_next = '0;

      if (!reset) begin
         case (state)
            ST_NORMAL: begin
               if (cpu_req_valid) begin
                  grant_any  = 1'b1;
                  grant_port = PORT_CPU;
               end else if (dma_req_valid) begin
                  grant_any  = 1'b1;
                  grant_port = PORT_DMA;
               end
            end
            ST_FORCE_DMA: begin
               if (dma_req_valid) begin
                  grant_any  = 1'b1;
                  grant_port = PORT_DMA;
               end
            end
            default: ;
         endcase
      end

      cpu_req_ready = grant_any && (grant_port == PORT_CPU);
      dma_req_ready = grant_any && (grant_port == PORT_DMA);

      // Counter tracks consecutive cycles of a waiting, un-granted DMA request.
      if (dma_req_valid && !dma_req_ready) begin
         starve_cnt_next = (starve_cnt == '1) ? starve_cnt : starve_cnt + 1'b1;
      end

      case (state)
         ST_NORMAL:    if (starve_cnt_next == LIMIT) state_next = ST_FORCE_DMA;
         ST_FORCE_DMA: if (dma_req_ready || !dma_req_valid) state_next = ST_NORMAL;
         default:      state_next = ST_NORMAL;
      endcase
   end

   assign sel_req      = (grant_port == PORT_DMA) ? dma_req : cpu_req;
   assign sel_in_range = addr_in_range(sel_req.addr, MEM_DEPTH);

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if (grant_any) begin
         mem_addr  = sel_req.addr;
         mem_wdata = sel_req.wdata;
         mem_we    = sel_req.we && sel_in_range;
         mem_re    = !sel_req.we && sel_in_range;
      end
   end

   assign dma_starved    = (state == ST_FORCE_DMA);
   assign dbg_state      = state;
   assign dbg_starve_cnt = starve_cnt;

   dmem_rsp_reg u_cpu_rsp (
      .clk       (clk),
      .reset     (reset),
      .accept    (cpu_req_ready),
      .is_load   (!sel_req.we),
      .err       (!sel_in_range),
      .mem_rdata (mem_rdata),
      .rsp_valid (cpu_rsp_valid),
      .rsp_rdata (cpu_rsp_rdata),
      .rsp_err   (cpu_rsp_err)
   );

   dmem_rsp_reg u_dma_rsp (
      .clk       (clk),
      .reset     (reset),
      .accept    (dma_req_ready),
      .is_load   (!sel_req.we),
      .err       (!sel_in_range),
      .mem_rdata (mem_rdata),
      .rsp_valid (dma_rsp_valid),
      .rsp_rdata (dma_rsp_rdata),
      .rsp_err   (dma_rsp_err)
   );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table, directed corner sequences and a
// randomized run against a grant/memory reference model.
module tb_dmem_port_arbiter;
   import dmem_arb_pkg::*;

   localparam int unsigned MEM_DEPTH    = 256;
   localparam int unsigned STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
   logic [31:0] cpu_req_addr, cpu_req_wdata;
   logic        cpu_rsp_valid, cpu_rsp_err;
   logic [31:0] cpu_rsp_rdata;
   logic        dma_req_valid, dma_req_ready, dma_req_we;
   logic [31:0] dma_req_addr, dma_req_wdata;
   logic        dma_rsp_valid, dma_rsp_err;
   logic [31:0] dma_rsp_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re;
   logic        dma_starved;
   arb_state_e  dbg_state;
   logic [7:0]  dbg_starve_cnt;

   logic [31:0] mem     [MEM_DEPTH];
   logic [31:0] ref_mem [MEM_DEPTH];
   logic        mem_init;

   int total = 0;
   int bad   = 0;

   // ---------------- clock / reset / memory ----------------
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   assign mem_rdata = (mem_addr[31:10] == 22'd0) ? mem[mem_addr[9:2]] : 32'h0;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= init_word(i);
      end else if (mem_we && mem_addr[31:10] == 22'd0) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   dmem_port_arbiter #(.MEM_DEPTH(MEM_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
      .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
      .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_we(dma_req_we),
      .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
      .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata), .dma_rsp_err(dma_rsp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .dma_starved(dma_starved),
      .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
   );

   // ---------------- driver / check tasks ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
      dma_req_valid = 1'b0; dma_req_we = 1'b0; dma_req_addr = '0; dma_req_wdata = '0;
   endtask

   task automatic drive_cpu(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wdata;
   endtask

   task automatic drive_dma(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      dma_req_valid = 1'b1; dma_req_we = we; dma_req_addr = addr; dma_req_wdata = wdata;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        cv, cwe;
      logic [31:0] ca;
      logic        dv, dwe;
      logic [31:0] da;
      logic [31:0] wd;
      logic        e_crdy, e_drdy, e_we, e_re;
      logic [31:0] e_addr;
   } vec_t;

   vec_t vecs[8];

   // ---------------- scoreboard / model state ----------------
   logic [32:0] cpu_exp_q[$];
   logic [32:0] dma_exp_q[$];
   mem_req_t    creq, dreq, greq;
   logic        cp, dp, cg, dg, any_g, forced, inr;
   logic [32:0] e;
   logic [31:0] c_last, d_last;
   int          waited, dut_dma_wait, idx;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; mem_init = 1'b1;
      idle();
      for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = init_word(i);
      tick(); tick();
      mem_init = 1'b0;

      // Reset with both requesters valid
      drive_cpu(1'b0, 32'h0, 32'h0);
      drive_dma(1'b0, 32'h4, 32'h0);
      @(negedge clk);
      chk("rst_cpu_rdy", cpu_req_ready, 0);
      chk("rst_dma_rdy", dma_req_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_cpu_rsp_v", cpu_rsp_valid, 0);
      chk("rst_dma_rsp_v", dma_rsp_valid, 0);
      chk("rst_cpu_rdata", cpu_rsp_rdata, 0);
      chk("rst_dma_err", dma_rsp_err, 0);
      chk("rst_starved", dma_starved, 0);
      chk("rst_cnt", dbg_starve_cnt, 0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rel_cpu_rdy", cpu_req_ready, 1);
      chk("rel_dma_rdy", dma_req_ready, 0);
      tick();
      idle();
      @(negedge clk);
      tick();

      // Single-cycle vectors, each started from an idle NORMAL state
      vecs[0] = '{1'b1, 1'b0, 32'h08,  1'b0, 1'b0, 32'h0,   32'hC0DE_0008, 1'b1, 1'b0, 1'b0, 1'b1, 32'h08};
      vecs[1] = '{1'b1, 1'b1, 32'h0C,  1'b0, 1'b0, 32'h0,   32'hC0DE_000C, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0C};
      vecs[2] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h14,  32'hC0DE_0014, 1'b0, 1'b1, 1'b0, 1'b1, 32'h14};
      vecs[3] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h18,  32'hC0DE_0018, 1'b0, 1'b1, 1'b1, 1'b0, 32'h18};
      vecs[4] = '{1'b1, 1'b0, 32'h1C,  1'b1, 1'b1, 32'h30,  32'hC0DE_0030, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1C};
      vecs[5] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[6] = '{1'b1, 1'b1, 32'h3FC, 1'b0, 1'b0, 32'h0,   32'hC0DE_03FC, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3FC};
      vecs[7] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h400, 32'hC0DE_0400, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400};
      for (int i = 0; i < 8; i++) begin
         cpu_req_valid = vecs[i].cv; cpu_req_we = vecs[i].cwe; cpu_req_addr = vecs[i].ca;
         cpu_req_wdata = vecs[i].wd;
         dma_req_valid = vecs[i].dv; dma_req_we = vecs[i].dwe; dma_req_addr = vecs[i].da;
         dma_req_wdata = vecs[i].wd;
         @(negedge clk);
         chk("vec_cpu_rdy", cpu_req_ready, vecs[i].e_crdy);
         chk("vec_dma_rdy", dma_req_ready, vecs[i].e_drdy);
         chk("vec_mem_we", mem_we, vecs[i].e_we);
         chk("vec_mem_re", mem_re, vecs[i].e_re);
         chk("vec_mem_addr", mem_addr, vecs[i].e_addr);
         chk("vec_mem_wdata", mem_wdata, (vecs[i].e_crdy || vecs[i].e_drdy) ? vecs[i].wd : 32'h0);
         if (vecs[i].e_we) ref_mem[vecs[i].e_addr[9:2]] = vecs[i].wd;
         tick();
         idle();
         @(negedge clk);
         chk("vec_cpu_rsp_v", cpu_rsp_valid, vecs[i].e_crdy);
         chk("vec_dma_rsp_v", dma_rsp_valid, vecs[i].e_drdy);
         tick();
      end

      // CPU store then load of the same word
      drive_cpu(1'b1, 32'h10, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("st_cpu_rdy", cpu_req_ready, 1);
      chk("st_mem_we", mem_we, 1);
      chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      ref_mem[4] = 32'hDEAD_BEEF;
      tick();
      drive_cpu(1'b0, 32'h10, 32'h0);
      @(negedge clk);
      chk("st_rsp_v", cpu_rsp_valid, 1);
      chk("ld_mem_re", mem_re, 1);
      tick();
      idle();
      @(negedge clk);
      chk("ld_rsp_v", cpu_rsp_valid, 1);
      chk("ld_rsp_rdata", cpu_rsp_rdata, 32'hDEAD_BEEF);
      chk("ld_rsp_err", cpu_rsp_err, 0);
      tick();
      @(negedge clk);
      chk("ld_rsp_pulse", cpu_rsp_valid, 0);
      tick();

      // Contention: grant pattern C,C,C,C,D repeating
      drive_cpu(1'b0, 32'h20, 32'h0);
      drive_dma(1'b0, 32'h24, 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("cont_cpu_rdy", cpu_req_ready, (i % 5 == 4) ? 0 : 1);
         chk("cont_dma_rdy", dma_req_ready, (i % 5 == 4) ? 1 : 0);
         chk("cont_starved", dma_starved, (i % 5 == 4) ? 1 : 0);
         tick();
      end
      idle();
      @(negedge clk);
      tick();

      // DMA alone: three back-to-back loads
      for (int k = 0; k < 3; k++) begin
         drive_dma(1'b0, 32'h40 + 32'(k * 4), 32'h0);
         @(negedge clk);
         chk("dma3_rdy", dma_req_ready, 1);
         if (k > 0) begin
            chk("dma3_rsp_v", dma_rsp_valid, 1);
            chk("dma3_rdata", dma_rsp_rdata, ref_mem[16 + k - 1]);
         end
         tick();
      end
      idle();
      @(negedge clk);
      chk("dma3_rsp_v_last", dma_rsp_valid, 1);
      chk("dma3_rdata_last", dma_rsp_rdata, ref_mem[18]);
      tick();
      @(negedge clk);
      chk("dma3_rsp_end", dma_rsp_valid, 0);
      tick();

      // Out-of-range load and store
      drive_cpu(1'b0, 32'h400, 32'h0);
      @(negedge clk);
      chk("oor_ld_rdy", cpu_req_ready, 1);
      chk("oor_ld_re", mem_re, 0);
      tick();
      drive_cpu(1'b1, 32'h400, 32'h1234_5678);
      @(negedge clk);
      chk("oor_ld_rsp_v", cpu_rsp_valid, 1);
      chk("oor_ld_err", cpu_rsp_err, 1);
      chk("oor_ld_rdata", cpu_rsp_rdata, 0);
      chk("oor_st_we", mem_we, 0);
      tick();
      drive_cpu(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("oor_st_err", cpu_rsp_err, 1);
      tick();
      idle();
      @(negedge clk);
      chk("oor_w0_rdata", cpu_rsp_rdata, ref_mem[0]);
      chk("oor_w0_err", cpu_rsp_err, 0);
      tick();

      // Reset asserted during a DMA accept cycle
      drive_cpu(1'b0, 32'h50, 32'h0);
      drive_dma(1'b0, 32'h44, 32'h0);
      tick(); tick();
      cpu_req_valid = 1'b0;
      @(negedge clk);
      chk("rsta_cnt_before", dbg_starve_cnt, 2);
      chk("rsta_dma_rdy", dma_req_ready, 1);
      reset = 1'b1;
      #1;
      chk("rsta_dma_rdy_rst", dma_req_ready, 0);
      tick();
      chk("rsta_rsp_v", dma_rsp_valid, 0);
      reset = 1'b0;
      idle();
      @(negedge clk);
      chk("rsta_rsp_v_after", dma_rsp_valid, 0);
      chk("rsta_cnt_after", dbg_starve_cnt, 0);
      chk("rsta_state", dbg_state, ST_NORMAL);
      tick();

      // Randomized traffic against the reference model
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cp = 1'b0; dp = 1'b0; waited = 0; dut_dma_wait = 0;
      c_last = '0; d_last = '0;
      creq = '0; dreq = '0;
      repeat (400) begin
         if (!cp && $urandom_range(0, 9) < 6) begin
            cp = 1'b1;
            creq.we = 1'($urandom_range(0, 1));
            creq.addr = 32'($urandom_range(0, 299)) << 2;
            creq.wdata = $urandom;
         end
         if (!dp && $urandom_range(0, 9) < 5) begin
            dp = 1'b1;
            dreq.we = 1'($urandom_range(0, 1));
            dreq.addr = 32'($urandom_range(0, 299)) << 2;
            dreq.wdata = $urandom;
         end
         cpu_req_valid = cp; cpu_req_we = creq.we; cpu_req_addr = creq.addr; cpu_req_wdata = creq.wdata;
         dma_req_valid = dp; dma_req_we = dreq.we; dma_req_addr = dreq.addr; dma_req_wdata = dreq.wdata;
         @(negedge clk);

         // DMA is owed the port once it has waited STARVE_LIMIT cycles
         forced = (waited == STARVE_LIMIT);
         cg = cp && !forced;
         dg = dp && (forced || !cp);
         any_g = cg || dg;
         greq = dg ? dreq : creq;
         inr = greq.addr < MEM_DEPTH * 4;
         chk("rnd_cpu_rdy", cpu_req_ready, cg);
         chk("rnd_dma_rdy", dma_req_ready, dg);
         chk("rnd_starved", dma_starved, forced);
         chk("rnd_mem_addr", mem_addr, any_g ? greq.addr : 32'h0);
         chk("rnd_mem_wdata", mem_wdata, any_g ? greq.wdata : 32'h0);
         chk("rnd_mem_we", mem_we, any_g && greq.we && inr);
         chk("rnd_mem_re", mem_re, any_g && !greq.we && inr);

         chk("rnd_cpu_rsp_v", cpu_rsp_valid, cpu_exp_q.size() != 0);
         if (cpu_exp_q.size() != 0) begin
            e = cpu_exp_q.pop_front();
            chk("rnd_cpu_err", cpu_rsp_err, e[32]);
            chk("rnd_cpu_rdata", cpu_rsp_rdata, e[31:0]);
         end
         chk("rnd_dma_rsp_v", dma_rsp_valid, dma_exp_q.size() != 0);
         if (dma_exp_q.size() != 0) begin
            e = dma_exp_q.pop_front();
            chk("rnd_dma_err", dma_rsp_err, e[32]);
            chk("rnd_dma_rdata", dma_rsp_rdata, e[31:0]);
         end

         if (dma_req_valid && dma_req_ready) begin
            chk("rnd_dma_wait_bound", dut_dma_wait <= STARVE_LIMIT, 1);
            dut_dma_wait = 0;
         end else if (dma_req_valid) begin
            dut_dma_wait++;
         end

         if (any_g) begin
            idx = int'(greq.addr >> 2);
            if (!inr)          e = {1'b1, 32'h0};
            else if (!greq.we) e = {1'b0, ref_mem[idx]};
            else               e = {1'b0, cg ? c_last : d_last};
            if (inr && greq.we) ref_mem[idx] = greq.wdata;
            if (cg) begin
               c_last = e[31:0];
               cpu_exp_q.push_back(e);
            end else begin
               d_last = e[31:0];
               dma_exp_q.push_back(e);
            end
         end
         waited = (dp && !dg) ? ((waited < 255) ? waited + 1 : waited) : 0;
         if (cg) cp = 1'b0;
         if (dg) dp = 1'b0;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
